// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and default widths for the two-master Wishbone arbiter
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

endpackage

// File: rtl/wb_rr_pick.sv
// rtl/wb_rr_pick.sv - 2-way round-robin selector; on a tie the master that was not last granted wins
module wb_rr_pick (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_gnt;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master Wishbone classic arbiter, registered round-robin grant
// Optional watchdog: define WB_ARB_TIMEOUT_EN to error-terminate transfers that never ack.
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int SW      = DW / 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,

  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [SW-1:0] m0_sel,
  input  logic          m0_we,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  output logic          m0_err,

  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [SW-1:0] m1_sel,
  input  logic          m1_we,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          m1_err,

  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic [SW-1:0] s_sel,
  output logic          s_we,
  output logic          s_cyc,
  output logic          s_stb,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ack
);

  arb_state_e state, state_nxt;
  logic       last_gnt, last_gnt_nxt;
  logic       gnt_valid, gnt_idx;
  logic       tmo_hit;

  wb_rr_pick u_pick (
    .req       ({m1_cyc & m1_stb, m0_cyc & m0_stb}),
    .last_gnt  (last_gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] tmo_cnt;

  // Held at zero while idle, so every grant starts counting from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (!s_ack) begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  assign tmo_hit = (state != IDLE) && !s_ack && (tmo_cnt == TMO_LAST);
  assign m0_err  = tmo_hit && (state == GNT0);
  assign m1_err  = tmo_hit && (state == GNT1);
`else
  assign tmo_hit = 1'b0;
  assign m0_err  = 1'b0;
  assign m1_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // A master dropping cyc ends its tenure just like an ack does.
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          state_nxt    = gnt_idx ? GNT1 : GNT0;
          last_gnt_nxt = gnt_idx;
        end
      end
      GNT0: begin
        if (s_ack || !m0_cyc || tmo_hit) state_nxt = IDLE;
      end
      GNT1: begin
        if (s_ack || !m1_cyc || tmo_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_sel   = '0;
    s_we    = 1'b0;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    case (state)
      GNT0: begin
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_sel   = m0_sel;
        s_we    = m0_we;
        s_cyc   = m0_cyc;
        s_stb   = m0_stb;
      end
      GNT1: begin
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_sel   = m1_sel;
        s_we    = m1_we;
        s_cyc   = m1_cyc;
        s_stb   = m1_stb;
      end
      default: ;
    endcase
  end

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_ack   = s_ack && (state == GNT0);
  assign m1_ack   = s_ack && (state == GNT1);

endmodule
